// File: rtl/rggen_apb_register_bridge.sv
// APB3/APB4 slave front end: one APB transfer becomes one register access request.
// Latency: valid one cycle after psel, pready one cycle after ready; watchdog forces an error response.
module rggen_apb_register_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic                     i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  output logic                     o_pready,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_pslverr,
  output logic                     o_register_valid,
  output logic                     o_register_write,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH-1:0]     o_register_mask,
  input  logic                     i_register_ready,
  input  logic                     i_register_error,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_LAST_I);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                   state;
  state_e                   state_next;
  logic [CNT_WIDTH-1:0]     busy_count;
  logic                     timeout;
  logic [BUS_WIDTH-1:0]     strb_mask;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [BUS_WIDTH-1:0]     mask_q;
  logic [BUS_WIDTH-1:0]     prdata_q;
  logic                     pslverr_q;

  // The access phase is implied by the FSM, so penable carries no information here.
  logic unused_penable;
  assign unused_penable = i_penable;

  // Expiry fires on the last allowed BUSY cycle; a ready in that same cycle takes precedence.
  assign timeout = (TIMEOUT_CYCLES > 0) && (state == BUSY) && !i_register_ready &&
                   (busy_count >= CNT_LAST);

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strb_mask[8*i+:8] = {8{i_pstrb[i]}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_psel) state_next = BUSY;
      BUSY:    if (i_register_ready || timeout) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_register_valid = 1'b0;
    o_pready         = 1'b0;
    o_prdata         = '0;
    o_pslverr        = 1'b0;
    case (state)
      BUSY: o_register_valid = 1'b1;
      RESPOND: begin
        o_pready  = 1'b1;
        o_prdata  = prdata_q;
        o_pslverr = pslverr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      mask_q       <= '0;
    end else if ((state == IDLE) && i_psel) begin
      write_q      <= i_pwrite;
      address_q    <= i_paddr;
      write_data_q <= i_pwdata;
      mask_q       <= i_pwrite ? strb_mask : '1;
    end
  end

  // Clearing while IDLE is equivalent to clearing on BUSY entry, since BUSY is only entered from IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_count <= '0;
    end else if (state == IDLE) begin
      busy_count <= '0;
    end else if ((state == BUSY) && (busy_count != CNT_MAX)) begin
      busy_count <= busy_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if ((state == BUSY) && i_register_ready) begin
      prdata_q  <= write_q ? '0 : i_register_read_data;
      pslverr_q <= i_register_error;
    end else if (timeout) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b1;
    end
  end

  assign o_register_write      = write_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_mask       = mask_q;

endmodule
